// File: rtl/wb_pkg.sv
// Shared Wishbone widths, register map constants and slave FSM state type.
// Every Wishbone block imports this package.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 8;
  localparam int WB_DATA_WIDTH = 32;

  localparam int WB_REG_CTRL     = 0;
  localparam int WB_REG_STAT     = 1;
  localparam int WB_REG_SCRATCH0 = 2;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_CNT_CLR = 1;

  typedef logic [WB_ADDR_WIDTH-1:0] wb_addr_t;
  typedef logic [WB_DATA_WIDTH-1:0] wb_data_t;

  typedef enum logic [1:0] {
    WBS_IDLE,
    WBS_WAIT,
    WBS_ACK
  } wb_slv_state_t;

  typedef struct packed {
    logic     we;
    wb_addr_t adr;
    wb_data_t dat;
  } wb_req_t;

endpackage

// File: rtl/wb_slave_fsm.sv
// Wishbone classic-cycle handshake: accepts a request, inserts wait states,
// then pulses ack_o for one cycle. Flags the edge on which the transfer takes effect.
module wb_slave_fsm
  import wb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cyc_i,
  input  logic     stb_i,
  input  logic     we_i,
  input  wb_addr_t adr_i,
  input  wb_data_t dat_i,
  output logic     ack_o,
  output logic     commit_o,
  output wb_req_t  cmd_o
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_slv_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  wb_req_t       req_q, req_d;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    commit_o = 1'b0;
    unique case (state_q)
      WBS_IDLE: begin
        if (cyc_i && stb_i) begin
          req_d = '{we: we_i, adr: adr_i, dat: dat_i};
          if (WAIT_STATES == 0) begin
            state_d  = WBS_ACK;
            commit_o = 1'b1;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WBS_WAIT;
          end
        end
      end
      WBS_WAIT: begin
        if (!(cyc_i && stb_i)) begin
          state_d = WBS_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = WBS_ACK;
          commit_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WBS_ACK:  state_d = WBS_IDLE;
      default:  state_d = WBS_IDLE;
    endcase
  end

  // With zero wait states the request commits on the edge that samples it,
  // so the consumer must see the live bus values rather than the latched copy.
  assign cmd_o = req_d;
  assign ack_o = (state_q == WBS_ACK);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= WBS_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone CSR slave: CTRL, STAT (write counter + irq pending) and scratch registers,
// behind a wait-state handshake FSM, with a level interrupt.
module wb_slave_regfile
  import wb_pkg::*;
#(
  parameter int          NUM_REGS    = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int          STAT_CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     irq_o
);

  localparam int NUM_SCR = NUM_REGS - WB_REG_SCRATCH0;
  localparam int SCR_IW  = (NUM_SCR > 1) ? $clog2(NUM_SCR) : 1;

  wb_req_t cmd;
  logic    commit;

  wb_slave_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .dat_i   (dat_i),
    .ack_o   (ack_o),
    .commit_o(commit),
    .cmd_o   (cmd)
  );

  wb_data_t                       ctrl_q, ctrl_d;
  logic [NUM_SCR-1:0][WB_DATA_WIDTH-1:0] scr_q, scr_d;
  logic [STAT_CNT_W-1:0]          cnt_q, cnt_d;
  logic                           pend_q, pend_d;
  wb_data_t                       dat_q, dat_d;

  logic              is_ctrl, is_stat, is_scr;
  logic [SCR_IW-1:0] scr_idx;
  wb_data_t          stat_word, rdata;
  logic              set_pend, clr_pend;

  always_comb begin
    is_ctrl = (cmd.adr == wb_addr_t'(WB_REG_CTRL));
    is_stat = (cmd.adr == wb_addr_t'(WB_REG_STAT));
    is_scr  = (cmd.adr >= wb_addr_t'(WB_REG_SCRATCH0)) && (int'(cmd.adr) < NUM_REGS);
    scr_idx = SCR_IW'(cmd.adr - wb_addr_t'(WB_REG_SCRATCH0));

    stat_word                   = '0;
    stat_word[STAT_CNT_W-1:0]   = cnt_q;
    stat_word[WB_DATA_WIDTH-1]  = pend_q;

    rdata = '0;
    if (is_ctrl)      rdata = ctrl_q;
    else if (is_stat) rdata = stat_word;
    else if (is_scr)  rdata = scr_q[scr_idx];
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    scr_d    = scr_q;
    cnt_d    = cnt_q;
    dat_d    = '0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    if (commit) begin
      if (cmd.we) begin
        if (is_ctrl) begin
          ctrl_d               = cmd.dat;
          ctrl_d[CTRL_CNT_CLR] = 1'b0;
          cnt_d = cmd.dat[CTRL_CNT_CLR] ? '0 : cnt_q + 1'b1;
        end else if (is_scr) begin
          scr_d[scr_idx] = cmd.dat;
          cnt_d          = cnt_q + 1'b1;
          set_pend       = ctrl_q[CTRL_IRQ_EN];
        end
      end else begin
        // Read data is registered so a STAT read returns pending as it was before the clear.
        dat_d    = rdata;
        clr_pend = is_stat;
      end
    end
    pend_d = set_pend ? 1'b1 : (clr_pend ? 1'b0 : pend_q);
  end

  // NOTE: the scratch array is small and must read 0 after reset, so it is reset like any register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dat_q  <= dat_d;
    end
  end

  assign dat_o = dat_q;
  assign irq_o = pend_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench: one slave with zero wait states (d=0) and one with three (d=1),
// driven by a simple Wishbone master task; expectations are hand-computed.
module tb_wb_slave_regfile;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        cyc, stb, we;
  logic [1:0][7:0]   adr;
  logic [1:0][31:0]  wdat;
  logic              ack0, ack1, irq0, irq1;
  logic [31:0]       rdat0, rdat1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_slave_regfile #(.NUM_REGS(4), .WAIT_STATES(0), .STAT_CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .dat_i(wdat[0]), .ack_o(ack0), .dat_o(rdat0), .irq_o(irq0)
  );

  wb_slave_regfile #(.NUM_REGS(4), .WAIT_STATES(3), .STAT_CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .dat_i(wdat[1]), .ack_o(ack1), .dat_o(rdat1), .irq_o(irq1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d != 0) ? ack1 : ack0;
  endfunction

  function automatic logic [31:0] dat_of(input int d);
    return (d != 0) ? rdat1 : rdat0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc   = '0;
    stb   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transfer; lat counts edges from the sampling edge to the edge that raises ack.
  task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output int lat);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
    r   = '0;
    lat = 0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack_of(d)) begin
        lat = i;
        r   = dat_of(d);
      end
    end
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (lat == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL xfer_timeout: dut %0d adr %h got no ack expected ack within 16 clocks", d, a);
    end
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] r;
    int          lat;
    xfer(d, 1'b1, a, wd, r, lat);
  endtask

  task automatic rd(input int d, input logic [7:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    int          lat;
    xfer(d, 1'b0, a, '0, r, lat);
    check({tag, "_lat"}, 32'(lat), (d != 0) ? 32'd4 : 32'd1);
    check(tag, r, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw;
    logic [31:0] r;
    int          lat;

    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0;
    do_reset();
    #1;
    check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rst_irq", {30'd0, irq1, irq0}, 32'd0);
    check("rst_dat0", rdat0, 32'd0);
    check("rst_dat1", rdat1, 32'd0);

    // Zero wait states: scratch write/read and counter.
    wr(0, 8'd2, 32'hA5);
    rd(0, 8'd2, 32'hA5, "scr2_read");
    rd(0, 8'd1, 32'h1, "stat_cnt1");

    // Three wait states: CTRL read after reset, ack exactly one cycle wide.
    rd(1, 8'd0, 32'h0, "ws3_ctrl_read");
    @(posedge clk); #1;
    check("ws3_ack_width", {31'd0, ack1}, 32'd0);
    check("ws3_dat_drop", rdat1, 32'd0);

    // Interrupt set, clear on STAT read, masking, counter clear.
    do_reset();
    wr(0, 8'd0, 32'h1);
    wr(0, 8'd3, 32'h5A);
    check("irq_set", {31'd0, irq0}, 32'd1);
    rd(0, 8'd1, 32'h8000_0002, "stat_pend");
    check("irq_clr", {31'd0, irq0}, 32'd0);
    wr(0, 8'd2, 32'h1);
    wr(0, 8'd0, 32'h0);
    check("irq_masked", {31'd0, irq0}, 32'd0);
    rd(0, 8'd1, 32'h8000_0004, "stat_pend_kept");
    wr(0, 8'd0, 32'h1);
    check("irq_after_clr", {31'd0, irq0}, 32'd0);
    wr(0, 8'd0, 32'h3);
    rd(0, 8'd0, 32'h1, "ctrl_clr_reads0");
    rd(0, 8'd1, 32'h0, "stat_cnt_clr");

    // Out-of-range and STAT writes are acked but have no effect.
    wr(0, 8'd4, 32'hFF);
    rd(0, 8'd4, 32'h0, "oor_read");
    wr(0, 8'd1, 32'h1234);
    rd(0, 8'd1, 32'h0, "stat_ro");
    rd(0, 8'd2, 32'h1, "scr2_kept");

    // Abort during WAIT: drop cyc/stb after two edges.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'd2; wdat[1] = 32'h77;
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      saw |= ack1;
    end
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      saw |= ack1;
    end
    check("abort_no_ack", {31'd0, saw}, 32'd0);
    rd(1, 8'd2, 32'h0, "abort_scr2");
    rd(1, 8'd1, 32'h0, "abort_stat");

    // adr/we/dat changing during WAIT must not alter the latched request.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'd2; wdat[1] = 32'h33;
    @(posedge clk);
    @(negedge clk);
    we[1] = 1'b0; adr[1] = 8'd3; wdat[1] = 32'hDEAD;
    lat = 0;
    for (int i = 2; i <= 16 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ack1) lat = i;
    end
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    check("latched_lat", 32'(lat), 32'd4);
    rd(1, 8'd2, 32'h33, "latched_scr2");
    rd(1, 8'd3, 32'h0, "latched_scr3");
    rd(1, 8'd1, 32'h1, "latched_stat");

    // Reset in the middle of a waited write with an interrupt pending.
    wr(1, 8'd0, 32'h1);
    wr(1, 8'd2, 32'h11);
    check("pre_rst_irq", {31'd0, irq1}, 32'd1);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'd3; wdat[1] = 32'h99;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack", {31'd0, ack1}, 32'd0);
    check("midrst_irq", {31'd0, irq1}, 32'd0);
    check("midrst_dat", rdat1, 32'd0);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    rst_n = 1'b1;
    rd(1, 8'd0, 32'h0, "midrst_ctrl");
    rd(1, 8'd2, 32'h0, "midrst_scr2");
    rd(1, 8'd3, 32'h0, "midrst_scr3");
    rd(1, 8'd1, 32'h0, "midrst_stat");

    // Write counter wraps at 256.
    for (int i = 0; i < 255; i++) wr(0, 8'd2, 32'(i));
    rd(0, 8'd1, 32'h0000_00FF, "cnt_255");
    wr(0, 8'd3, 32'h0);
    rd(0, 8'd1, 32'h0, "cnt_wrap");
    xfer(0, 1'b0, 8'd2, '0, r, lat);
    check("scr2_last", r, 32'd254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
